deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deser_if.sv | 22 ++
 rtl/deserializer.sv | 107 ++++++++++
 tb/tb_deserializer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/deser_if.sv
// Serial-in / parallel-out bundle for the deserializer.
// slave is the deserializer side; master is the producer/consumer side.
interface deser_if;
  localparam int unsigned W = 16;
  localparam int unsigned MW = 4;

  logic          ser_data_i;
  logic          ser_data_val_i;
  logic [W-1:0]  deser_data_o;
  logic [MW-1:0] deser_data_mod_o;
  logic          deser_data_val_o;

  modport slave (
    input  ser_data_i, ser_data_val_i,
    output deser_data_o, deser_data_mod_o, deser_data_val_o
  );

  modport master (
    output ser_data_i, ser_data_val_i,
    input  deser_data_o, deser_data_mod_o, deser_data_val_o
  );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial to 16-bit word deserializer with a one-cycle output strobe.
// Define DESER_FLUSH_EN to flush a partial word after TIMEOUT idle cycles.
module deserializer #(
  parameter int unsigned TIMEOUT = 4
) (
  input logic    clk_i,
  input logic    rst_n_i,
  deser_if.slave bus
);
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, COLLECT, GAP} state_e;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must be in 1..255");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic [3:0]    mod_q, mod_d;
  logic          val_q, val_d;
  logic [W-1:0]  shift_nxt;
`ifdef DESER_FLUSH_EN
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  // State register and output flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      mod_q    <= '0;
      val_q    <= 1'b0;
`ifdef DESER_FLUSH_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      mod_q    <= mod_d;
      val_q    <= val_d;
`ifdef DESER_FLUSH_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Next-state, shift and strobe logic
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    mod_d     = mod_q;
    val_d     = 1'b0;
`ifdef DESER_FLUSH_EN
    to_cnt_d  = to_cnt_q;
`endif
    shift_nxt = {shift_q[W-2:0], bus.ser_data_i};

    if (bus.ser_data_val_i) begin
`ifdef DESER_FLUSH_EN
      to_cnt_d = '0;
`endif
      if (cnt_q == CW'(W - 1)) begin
        data_d  = shift_nxt;
        mod_d   = 4'd0;
        val_d   = 1'b1;
        shift_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        shift_d = shift_nxt;
        cnt_d   = (cnt_q == CW'(W)) ? cnt_q : cnt_q + CW'(1);
        state_d = COLLECT;
      end
    end else if (state_q != IDLE) begin
      state_d = GAP;
`ifdef DESER_FLUSH_EN
      to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TW'(1);
      // Partial word: left-align received bits, zero-fill the low end
      if (to_cnt_d == TW'(TIMEOUT) && cnt_q != '0) begin
        data_d   = W'(shift_q << (CW'(W) - cnt_q));
        mod_d    = cnt_q[3:0];
        val_d    = 1'b1;
        shift_d  = '0;
        cnt_d    = '0;
        to_cnt_d = '0;
        state_d  = IDLE;
      end
`endif
    end
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_mod_o = mod_q;
  assign bus.deser_data_val_o = val_q;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer; expected words are queued as bits are driven.
// Gap behaviour follows the DESER_FLUSH_EN setting of the build.
module tb_deserializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deser_if dif();

  deserializer #(.TIMEOUT(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (dif)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  mod;
  } exp_t;

  exp_t sb[$];
  int   strobe_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pop the scoreboard on every strobe
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dif.deser_data_val_o) begin
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check_val("spurious_strobe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("data", 32'(dif.deser_data_o), 32'(e.data));
        check_val("mod", 32'(dif.deser_data_mod_o), 32'(e.mod));
      end
    end
  end

  task automatic expect_word(input logic [15:0] d, input logic [3:0] m);
    exp_t e;
    e.data = d;
    e.mod  = m;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic b);
    dif.ser_data_val_i = v;
    dif.ser_data_i     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  // Send the top n bits of w, MSB first, one per cycle
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, w[15-i]);
  endtask

  initial begin
    logic [15:0] w;
    dif.ser_data_val_i = 1'b0;
    dif.ser_data_i     = 1'b0;
    rst_n = 1'b0;
    #12;
    check_val("rst_data", 32'(dif.deser_data_o), 32'h0);
    check_val("rst_mod", 32'(dif.deser_data_mod_o), 32'h0);
    check_val("rst_val", 32'(dif.deser_data_val_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Single word, then outputs must hold
    expect_word(16'hA5C3, 4'd0);
    send_bits(16'hA5C3, 16);
    idle(3);
    check_val("hold_data", 32'(dif.deser_data_o), 32'hA5C3);
    check_val("hold_val", 32'(dif.deser_data_val_o), 32'h0);

    // Mid-word asynchronous reset
    send_bits(16'h5A5A, 8);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_data", 32'(dif.deser_data_o), 32'h0);
    check_val("arst_mod", 32'(dif.deser_data_mod_o), 32'h0);
    check_val("arst_val", 32'(dif.deser_data_val_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    expect_word(16'h00FF, 4'd0);
    send_bits(16'h00FF, 16);
    idle(2);

    // Back-to-back words
    strobe_cyc.delete();
    expect_word(16'h1234, 4'd0);
    expect_word(16'hFFFF, 4'd0);
    send_bits(16'h1234, 16);
    send_bits(16'hFFFF, 16);
    idle(2);
    check_val("b2b_count", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() >= 2)
      check_val("b2b_spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd16);

`ifdef DESER_FLUSH_EN
    // Gap of 3 idles continues the word
    expect_word(16'hB000, 4'd0);
    send_bits(16'hB000, 5);
    idle(3);
    check_val("short_gap_val", 32'(dif.deser_data_val_o), 32'h0);
    send_bits(16'h0000, 11);
    idle(2);
    // Gap reaching TIMEOUT flushes on the 4th idle
    expect_word(16'hB000, 4'd5);
    send_bits(16'hB000, 5);
    idle(3);
    check_val("pre_flush_val", 32'(dif.deser_data_val_o), 32'h0);
    idle(1);
    check_val("flush_val", 32'(dif.deser_data_val_o), 32'h1);
    idle(8);
    check_val("post_flush_val", 32'(dif.deser_data_val_o), 32'h0);
`else
    // Long gap never flushes
    expect_word(16'hB000, 4'd0);
    send_bits(16'hB000, 5);
    idle(10);
    check_val("gap_no_flush", 32'(dif.deser_data_val_o), 32'h0);
    send_bits(16'h0000, 11);
    idle(2);
`endif

    // Random words with short gaps inside
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom);
      expect_word(w, 4'd0);
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, w[15-i]);
        if (i < 15 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check_val("drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
